// File: rtl/drop_speed_ctrl.sv
// Gravity speed controller: tracks lines/level and drives the clock-divider upperbound.
// Optional SPEED_RAMP_EN: level-derived bound changes ramp by LEVEL_STEP/16 per cycle.
module drop_speed_ctrl #(
  parameter logic [31:0] BASE_UB         = 32'd25_000_000,
  parameter logic [31:0] LEVEL_STEP      = 32'd2_000_000,
  parameter logic [31:0] MIN_UB          = 32'd2_500_000,
  parameter logic [31:0] SOFT_UB         = 32'd1_250_000,
  parameter logic [31:0] PAUSE_UB        = 32'hFFFF_FFFF,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned MAX_LEVEL       = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        pause,
  input  logic        soft_drop,
  input  logic        lines_valid,
  input  logic [2:0]  lines_cleared,
  output logic [31:0] upperbound,
  output logic [4:0]  level,
  output logic [15:0] total_lines,
  output logic        level_up
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  logic [4:0]  r_level;
  logic [15:0] r_total;
  logic [7:0]  r_lc;
  logic        r_level_up;
  logic [31:0] r_ub;
  logic        r_prev_lvl;

  logic [2:0]  w_n;
  logic [8:0]  w_sum;
  logic [16:0] w_tot;
  logic [31:0] w_prod;
  logic [31:0] w_lvl_tgt;
  logic [31:0] w_tgt;
  logic        w_is_lvl;
  logic [31:0] w_ub_next;

  assign w_n       = (lines_cleared > 3'd4) ? 3'd4 : lines_cleared;
  assign w_sum     = {1'b0, r_lc} + {6'd0, w_n};
  assign w_tot     = {1'b0, r_total} + {14'd0, w_n};
  assign w_prod    = {27'd0, r_level} * LEVEL_STEP;
  // Compare before subtracting so the level-derived bound never wraps below the floor.
  assign w_lvl_tgt = (w_prod > (BASE_UB - MIN_UB)) ? MIN_UB : (BASE_UB - w_prod);
  assign w_is_lvl  = (r_state == S_RUN) && !pause && !soft_drop;

  always_comb begin
    w_tgt = PAUSE_UB;
    if (r_state == S_RUN) begin
      if (pause)          w_tgt = PAUSE_UB;
      else if (soft_drop) w_tgt = SOFT_UB;
      else                w_tgt = w_lvl_tgt;
    end
  end

`ifdef SPEED_RAMP_EN
  localparam logic [31:0] RAMP_STEP = LEVEL_STEP >> 4;

  // Only level-to-level transitions ramp; entering/leaving pause or soft drop jumps.
  always_comb begin
    w_ub_next = w_tgt;
    if (w_is_lvl && r_prev_lvl) begin
      if (r_ub > w_tgt)
        w_ub_next = ((r_ub - w_tgt) > RAMP_STEP) ? (r_ub - RAMP_STEP) : w_tgt;
      else
        w_ub_next = ((w_tgt - r_ub) > RAMP_STEP) ? (r_ub + RAMP_STEP) : w_tgt;
    end
  end
`else
  always_comb begin
    w_ub_next = w_tgt;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_level    <= 5'd0;
      r_total    <= 16'd0;
      r_lc       <= 8'd0;
      r_level_up <= 1'b0;
      r_ub       <= PAUSE_UB;
      r_prev_lvl <= 1'b0;
    end else begin
      r_level_up <= 1'b0;
      r_ub       <= w_ub_next;
      r_prev_lvl <= w_is_lvl;
      case (r_state)
        S_IDLE: begin
          if (game_start) begin
            r_state    <= S_RUN;
            r_level    <= 5'd0;
            r_total    <= 16'd0;
            r_lc       <= 8'd0;
            r_prev_lvl <= 1'b0;
          end
        end
        S_RUN: begin
          if (game_over) begin
            r_state <= S_IDLE;
          end else if (game_start) begin
            r_level    <= 5'd0;
            r_total    <= 16'd0;
            r_lc       <= 8'd0;
            r_prev_lvl <= 1'b0;
          end else if (lines_valid) begin
            r_total <= w_tot[16] ? 16'hFFFF : w_tot[15:0];
            if (w_sum >= 9'(LINES_PER_LEVEL)) begin
              r_lc <= 8'(w_sum - 9'(LINES_PER_LEVEL));
              if (r_level < 5'(MAX_LEVEL)) begin
                r_level    <= r_level + 5'd1;
                r_level_up <= 1'b1;
              end
            end else begin
              r_lc <= w_sum[7:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign upperbound  = r_ub;
  assign level       = r_level;
  assign total_lines = r_total;
  assign level_up    = r_level_up;

endmodule

// File: doc/drop_speed_ctrl.md
Name: drop_speed_ctrl

Overview:
- Gravity speed controller for the Tetris core. It sits directly upstream of the clock divider and drives that divider's 32-bit upperbound input, so it sets the falling-piece tick period.
- Tracks cleared lines and the current level, and derives the divider bound from level, soft-drop and pause.
- Emits a one-cycle level-up strobe for the display and sound logic.

Parameters:
- BASE_UB, 25_000_000, upperbound at level 0.
- LEVEL_STEP, 2_000_000, upperbound reduction per level.
- MIN_UB, 2_500_000, floor on the level-derived upperbound.
- SOFT_UB, 1_250_000, upperbound while soft_drop is held.
- PAUSE_UB, 32'hFFFF_FFFF, upperbound while paused (divider effectively frozen).
- LINES_PER_LEVEL, 10, lines needed per level increment (2..255).
- MAX_LEVEL, 15, level saturation value (1..31).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- game_start  in  1  one-cycle pulse: clear counters, enter RUN
- game_over  in  1  one-cycle pulse: enter IDLE, hold counters
- pause  in  1  level; freezes gravity while high in RUN
- soft_drop  in  1  level; fast gravity while high in RUN
- lines_valid  in  1  one-cycle qualifier for lines_cleared
- lines_cleared  in  3  lines cleared by a lock (0..4)
- upperbound  out  32  registered bound to the clock divider
- level  out  5  current level
- total_lines  out  16  lines cleared this game
- level_up  out  1  one-cycle strobe on level increment

Behaviour:
- Reset values:
  - State is IDLE.
  - level=0, total_lines=0, internal line counter lc=0, level_up=0.
  - upperbound=PAUSE_UB.
- State IDLE:
  - upperbound=PAUSE_UB.
  - lines_valid is ignored.
  - game_start moves to RUN and clears level, total_lines and lc in the same edge.
- State RUN:
  - game_over moves to IDLE and takes priority over lines_valid in the same cycle.
  - game_start while in RUN restarts: counters clear and state stays RUN.
- Line accounting (RUN only, on lines_valid):
  - n = min(lines_cleared, 4).
  - total_lines += n, saturating at 16'hFFFF.
  - s = lc + n.
  - If s >= LINES_PER_LEVEL: lc <= s - LINES_PER_LEVEL. If level < MAX_LEVEL, level increments and level_up pulses high for exactly one cycle.
  - Otherwise lc <= s.
  - At most one level per lines_valid.
  - At MAX_LEVEL, lc still wraps but level and level_up do not change.
- Latency:
  - level, total_lines and level_up update on the edge that samples lines_valid.
  - upperbound reflects the new level on the following edge (2-cycle total from lines_valid).
- Upperbound target, evaluated every cycle in RUN with priority pause > soft_drop > level:
  - pause gives PAUSE_UB.
  - Else soft_drop gives SOFT_UB.
  - Else p = level*LEVEL_STEP (32-bit). If p > BASE_UB-MIN_UB the target is MIN_UB; else it is BASE_UB-p.
  - No underflow or wrap is permitted.
- pause or soft_drop changes reach upperbound 1 cycle after sampling.
- lines_valid is still accepted while paused.
- Reset asserted mid-game returns all outputs immediately (asynchronously) to their reset values.

Optional Feature:
- Macro: SPEED_RAMP_EN.
- Defined:
  - Level-derived changes move upperbound toward the target by at most LEVEL_STEP/16 per cycle, so speed transitions are smooth.
  - The last step lands exactly on the target with no overshoot.
  - pause, soft_drop, leaving pause, leaving soft_drop and game_start still jump directly.
- Undefined: upperbound jumps to the target on the next edge.

Test Plan:
- rst high then low -> upperbound=32'hFFFF_FFFF, level=0, total_lines=0, level_up=0; lines_valid with 3 in IDLE -> no change.
- game_start, then lines_valid with 4, 4, 2 -> total_lines=10, level=1, one level_up pulse on the third valid, upperbound=23_000_000 two cycles later.
- Reach level 11 -> upperbound=3_000_000; reach level 12 -> upperbound=2_500_000 (floor).
- Hold soft_drop at level 1 -> upperbound=1_250_000 next cycle; add pause -> 32'hFFFF_FFFF; release both -> 23_000_000.
- Drive lines_cleared=7 -> counted as 4. At level 15, lines_valid with 4 x3 -> level stays 15, no level_up, total_lines keeps counting.
- game_over and lines_valid in the same cycle -> state IDLE, counters unchanged. With SPEED_RAMP_EN, level 0->1 -> upperbound decreases by 125_000 per cycle over 16 cycles to 23_000_000.
